// File: rtl/xor_accum_if.sv
// xor_accum_if: valid/ready stream bundle between a word producer, xor_accum and a result consumer
//   in_valid_i/in_ready_o/in_data_i/in_last_i  input beat handshake, word and end-of-packet marker
//   clear_i                                    abort of the partial packet
//   out_valid_o/out_ready_i                    result handshake
//   out_data_o/out_parity_o/out_count_o/out_overflow_o  packet XOR, its parity, beat count, overflow
interface xor_accum_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i;
    logic             in_last_i;
    logic             clear_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_data_o;
    logic             out_parity_o;
    logic [CNT_W-1:0] out_count_o;
    logic             out_overflow_o;
    modport master (
        output in_valid_i, in_data_i, in_last_i, clear_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_parity_o, out_count_o, out_overflow_o
    );
    modport slave (
        input  in_valid_i, in_data_i, in_last_i, clear_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_parity_o, out_count_o, out_overflow_o
    );
endinterface

// File: rtl/xor_accum.sv
// xor_accum: folds a packet of WIDTH-bit words into a running XOR and reports result, parity, beat count, overflow
//   clk_i    rising-edge clock
//   rst_n_i  asynchronous active-low reset
//   bus      xor_accum_if slave side (input beats in, packet result out)
module xor_accum #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input logic        clk_i,
    input logic        rst_n_i,
    xor_accum_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_parity;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_overflow;
    logic             w_beat;
    logic             w_sat;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    assign bus.in_ready_o     = rst_n_i & (r_state == ACCUM) & ~bus.clear_i;
    assign bus.out_valid_o    = r_out_valid;
    assign bus.out_data_o     = r_out_data;
    assign bus.out_parity_o   = r_out_parity;
    assign bus.out_count_o    = r_out_count;
    assign bus.out_overflow_o = r_out_overflow;
    assign w_beat    = bus.in_valid_i & bus.in_ready_o;
    assign w_sat     = &r_cnt;
    assign w_acc_nxt = r_acc ^ bus.in_data_i;
    assign w_cnt_inc = w_sat ? r_cnt : r_cnt + CNT_W'(1);
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ACCUM)
            w_state_nxt = (w_beat & bus.in_last_i) ? HOLD : ACCUM;
        else
            w_state_nxt = bus.out_ready_i ? ACCUM : HOLD;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state        <= ACCUM;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_ovf          <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_parity   <= 1'b0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ACCUM && bus.clear_i) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_beat && bus.in_last_i) begin
                r_out_data     <= w_acc_nxt;
                r_out_parity   <= ^w_acc_nxt;
                r_out_count    <= w_cnt_inc;
                r_out_overflow <= r_ovf | w_sat;
                r_out_valid    <= 1'b1;
                r_acc          <= '0;
                r_cnt          <= '0;
                r_ovf          <= 1'b0;
            end else if (w_beat) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_inc;
                r_ovf <= r_ovf | w_sat;
            end
            if (r_state == HOLD && bus.out_ready_i)
                r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xor_accum.sv
// tb_xor_accum: table-driven cycle vectors plus hand sequences for reset, backpressure and overflow
module tb_xor_accum;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    int   n_pass = 0;
    int   n_tot  = 0;
    always #5 clk_i = ~clk_i;
    xor_accum_if #(.WIDTH(16), .CNT_W(8)) b1 ();
    xor_accum_if #(.WIDTH(16), .CNT_W(2)) b2 ();
    xor_accum #(.WIDTH(16), .CNT_W(8)) dut1 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(b1.slave));
    xor_accum #(.WIDTH(16), .CNT_W(2)) dut2 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(b2.slave));
    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        c;
        logic        r;
        logic        e_rdy;
        logic        e_ov;
        logic [15:0] e_d;
        logic        e_p;
        logic [7:0]  e_cnt;
        logic        e_of;
    } vec_t;
    vec_t tbl[26];
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s act=%0h exp=%0h", n, a, e);
    endtask
    task automatic drv(input logic v, input logic [15:0] d, input logic l, input logic c, input logic r);
        b1.in_valid_i  = v;
        b1.in_data_i   = d;
        b1.in_last_i   = l;
        b1.clear_i     = c;
        b1.out_ready_i = r;
    endtask
    task automatic chk1(input string t, input logic rdy, input logic ov, input logic [15:0] d,
                        input logic p, input logic [7:0] cnt, input logic of);
        chk({t, ".ready"}, 32'(b1.in_ready_o), 32'(rdy));
        chk({t, ".valid"}, 32'(b1.out_valid_o), 32'(ov));
        chk({t, ".data"}, 32'(b1.out_data_o), 32'(d));
        chk({t, ".parity"}, 32'(b1.out_parity_o), 32'(p));
        chk({t, ".count"}, 32'(b1.out_count_o), 32'(cnt));
        chk({t, ".ovf"}, 32'(b1.out_overflow_o), 32'(of));
    endtask
    initial begin
        tbl[0]  = '{1, 16'hA5A5, 1, 0, 1, 1, 0, 16'h0000, 0, 8'd0, 0};
        tbl[1]  = '{0, 16'h0000, 0, 0, 1, 0, 1, 16'hA5A5, 0, 8'd1, 0};
        tbl[2]  = '{1, 16'h00FF, 0, 0, 1, 1, 0, 16'hA5A5, 0, 8'd1, 0};
        tbl[3]  = '{1, 16'h0F0F, 0, 0, 1, 1, 0, 16'hA5A5, 0, 8'd1, 0};
        tbl[4]  = '{1, 16'hFFFF, 1, 0, 1, 1, 0, 16'hA5A5, 0, 8'd1, 0};
        tbl[5]  = '{1, 16'h0007, 1, 0, 1, 0, 1, 16'hF00F, 0, 8'd3, 0};
        tbl[6]  = '{1, 16'h0007, 1, 0, 1, 1, 0, 16'hF00F, 0, 8'd3, 0};
        tbl[7]  = '{0, 16'h0000, 0, 0, 1, 0, 1, 16'h0007, 1, 8'd1, 0};
        tbl[8]  = '{1, 16'h1234, 1, 0, 0, 1, 0, 16'h0007, 1, 8'd1, 0};
        tbl[9]  = '{1, 16'h5555, 1, 0, 0, 0, 1, 16'h1234, 1, 8'd1, 0};
        tbl[10] = '{1, 16'h5555, 1, 0, 0, 0, 1, 16'h1234, 1, 8'd1, 0};
        tbl[11] = '{1, 16'h5555, 1, 0, 0, 0, 1, 16'h1234, 1, 8'd1, 0};
        tbl[12] = '{1, 16'h5555, 1, 0, 0, 0, 1, 16'h1234, 1, 8'd1, 0};
        tbl[13] = '{1, 16'h5555, 1, 0, 0, 0, 1, 16'h1234, 1, 8'd1, 0};
        tbl[14] = '{1, 16'h5555, 1, 0, 1, 0, 1, 16'h1234, 1, 8'd1, 0};
        tbl[15] = '{1, 16'h0F00, 1, 0, 1, 1, 0, 16'h1234, 1, 8'd1, 0};
        tbl[16] = '{0, 16'h0000, 0, 0, 1, 0, 1, 16'h0F00, 0, 8'd1, 0};
        tbl[17] = '{1, 16'h1234, 0, 0, 1, 1, 0, 16'h0F00, 0, 8'd1, 0};
        tbl[18] = '{1, 16'hFFFF, 0, 1, 1, 0, 0, 16'h0F00, 0, 8'd1, 0};
        tbl[19] = '{1, 16'h0001, 1, 0, 1, 1, 0, 16'h0F00, 0, 8'd1, 0};
        tbl[20] = '{0, 16'h0000, 0, 0, 1, 0, 1, 16'h0001, 1, 8'd1, 0};
        tbl[21] = '{0, 16'h0000, 0, 1, 1, 0, 0, 16'h0001, 1, 8'd1, 0};
        tbl[22] = '{1, 16'h00F0, 1, 0, 0, 1, 0, 16'h0001, 1, 8'd1, 0};
        tbl[23] = '{0, 16'h0000, 0, 1, 0, 0, 1, 16'h00F0, 0, 8'd1, 0};
        tbl[24] = '{0, 16'h0000, 0, 0, 1, 0, 1, 16'h00F0, 0, 8'd1, 0};
        tbl[25] = '{0, 16'h0000, 0, 0, 1, 1, 0, 16'h00F0, 0, 8'd1, 0};
        b2.in_valid_i  = 1'b0;
        b2.in_data_i   = 16'h0000;
        b2.in_last_i   = 1'b0;
        b2.clear_i     = 1'b0;
        b2.out_ready_i = 1'b1;
        drv(1, 16'hA5A5, 1, 0, 1);
        #3;
        chk1("reset", 0, 0, 16'h0000, 0, 8'd0, 0);
        @(negedge clk_i);
        drv(0, 16'h0000, 0, 0, 1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk1("release", 1, 0, 16'h0000, 0, 8'd0, 0);
        for (int i = 0; i < 26; i++) begin
            @(negedge clk_i);
            drv(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].c, tbl[i].r);
            #1;
            chk1($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_d, tbl[i].e_p,
                 tbl[i].e_cnt, tbl[i].e_of);
        end
        @(negedge clk_i);
        drv(1, 16'hBEEF, 1, 0, 0);
        @(negedge clk_i);
        drv(0, 16'h0000, 0, 0, 0);
        #1;
        chk1("hold_beef", 0, 1, 16'hBEEF, 1, 8'd1, 0);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk1("async_rst", 0, 0, 16'h0000, 0, 8'd0, 0);
        @(negedge clk_i);
        drv(0, 16'h0000, 0, 0, 1);
        rst_n_i = 1'b1;
        #1;
        chk1("rst_rel", 1, 0, 16'h0000, 0, 8'd0, 0);
        @(negedge clk_i);
        drv(1, 16'h1111, 0, 0, 1);
        @(negedge clk_i);
        drv(0, 16'h0000, 0, 0, 1);
        #2;
        rst_n_i = 1'b0;
        #2;
        rst_n_i = 1'b1;
        @(negedge clk_i);
        drv(1, 16'h0002, 1, 0, 1);
        @(negedge clk_i);
        drv(0, 16'h0000, 0, 0, 1);
        #1;
        chk1("post_rst_pkt", 0, 1, 16'h0002, 1, 8'd1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            b2.in_valid_i = 1'b1;
            b2.in_data_i  = 16'h0001;
            b2.in_last_i  = (i == 4);
        end
        @(negedge clk_i);
        b2.in_valid_i = 1'b0;
        b2.in_last_i  = 1'b0;
        #1;
        chk("ovf.valid", 32'(b2.out_valid_o), 32'd1);
        chk("ovf.count", 32'(b2.out_count_o), 32'd3);
        chk("ovf.ovf", 32'(b2.out_overflow_o), 32'd1);
        chk("ovf.data", 32'(b2.out_data_o), 32'h0001);
        chk("ovf.parity", 32'(b2.out_parity_o), 32'd1);
        @(negedge clk_i);
        b2.in_valid_i = 1'b1;
        b2.in_data_i  = 16'h0002;
        b2.in_last_i  = 1'b1;
        @(negedge clk_i);
        b2.in_valid_i = 1'b0;
        b2.in_last_i  = 1'b0;
        #1;
        chk("ovf2.valid", 32'(b2.out_valid_o), 32'd1);
        chk("ovf2.ovf", 32'(b2.out_overflow_o), 32'd0);
        chk("ovf2.count", 32'(b2.out_count_o), 32'd1);
        chk("ovf2.data", 32'(b2.out_data_o), 32'h0002);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
